// File: rtl/map_draw_sequencer.sv
// map_draw_sequencer: sequences a full-screen redraw through the copy engine.
// It draws one background copy, then one copy per tile of the COLS x ROWS
// tile map, then requests a buffer-to-screen refresh.
// Optional build macro: SKIP_EMPTY_TILES_EN. When it is defined, map cells
// holding tile code 0 produce no tile copy.
module map_draw_sequencer #(
    parameter int COLS = 20,
    parameter int ROWS = 15,
    parameter int TILE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] bg_sel,
    output logic [8:0] map_addr,
    input  logic [3:0] map_tile,
    output logic       go,
    output logic       refresh,
    output logic [8:0] X,
    output logic [7:0] Y,
    output logic [1:0] memory_select,
    output logic [3:0] tile_select,
    input  logic       finished,
    output logic       busy,
    output logic       done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_BG_GO      = 4'd1;
    localparam logic [3:0] S_BG_WAIT    = 4'd2;
    localparam logic [3:0] S_FETCH      = 4'd3;
    localparam logic [3:0] S_FETCH_WAIT = 4'd4;
    localparam logic [3:0] S_TILE_GO    = 4'd5;
    localparam logic [3:0] S_TILE_WAIT  = 4'd6;
    localparam logic [3:0] S_NEXT       = 4'd7;
    localparam logic [3:0] S_REF_GO     = 4'd8;
    localparam logic [3:0] S_REF_WAIT   = 4'd9;
    localparam logic [3:0] S_DONE       = 4'd10;

    logic [3:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // State machine, tile counters and the registered copy-engine request fields.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            col           <= '0;
            row           <= '0;
            map_addr      <= '0;
            X             <= '0;
            Y             <= '0;
            memory_select <= '0;
            tile_select   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_BG_GO;
                        memory_select <= bg_sel;
                        X             <= '0;
                        Y             <= '0;
                        col           <= '0;
                        row           <= '0;
                        map_addr      <= '0;
                    end
                end
                S_BG_GO:   state <= S_BG_WAIT;
                S_BG_WAIT: if (finished) state <= S_FETCH;
                S_FETCH:   state <= S_FETCH_WAIT;
                S_FETCH_WAIT: begin
`ifdef SKIP_EMPTY_TILES_EN
                    if (map_tile == 4'd0) begin
                        state <= S_NEXT;
                    end else begin
                        state         <= S_TILE_GO;
                        tile_select   <= map_tile;
                        memory_select <= 2'b11;
                        X             <= 9'(int'(col) * TILE);
                        Y             <= 8'(int'(row) * TILE);
                    end
`else
                    state         <= S_TILE_GO;
                    tile_select   <= map_tile;
                    memory_select <= 2'b11;
                    X             <= 9'(int'(col) * TILE);
                    Y             <= 8'(int'(row) * TILE);
`endif
                end
                S_TILE_GO:   state <= S_TILE_WAIT;
                S_TILE_WAIT: if (finished) state <= S_NEXT;
                S_NEXT: begin
                    // Cells are visited in raster order, so row*COLS+col is
                    // tracked as a running address that steps by one and is
                    // already valid when FETCH is entered.
                    if (col == COL_LAST) begin
                        if (row == ROW_LAST) begin
                            state <= S_REF_GO;
                        end else begin
                            state    <= S_FETCH;
                            col      <= '0;
                            row      <= row + RW'(1);
                            map_addr <= map_addr + 9'd1;
                        end
                    end else begin
                        state    <= S_FETCH;
                        col      <= col + CW'(1);
                        map_addr <= map_addr + 9'd1;
                    end
                end
                S_REF_GO:   state <= S_REF_WAIT;
                S_REF_WAIT: if (finished) state <= S_DONE;
                S_DONE:     state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    // Single-cycle strobes and busy decode directly from the registered state.
    always_comb begin
        go      = (state == S_BG_GO) || (state == S_TILE_GO);
        refresh = (state == S_REF_GO);
        done    = (state == S_DONE);
        busy    = (state != S_IDLE);
    end

endmodule

// File: doc/map_draw_sequencer.md
MAP_DRAW_SEQUENCER -- requirements
Module: map_draw_sequencer

Interface
REQ-001 Parameter COLS, default 20, tile columns per screen (320/16).
REQ-002 Parameter ROWS, default 15, tile rows per screen (240/16).
REQ-003 Parameter TILE, default 16, tile edge in pixels.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request full redraw; sampled only in IDLE.
REQ-007 bg_sel  in  2  background image select (00 title, 01 game, 10 end); latched at start.
REQ-008 map_addr  out  9  tile-map RAM address, row*COLS+col.
REQ-009 map_tile  in  4  tile code from map RAM, valid 1 cycle after map_addr changes.
REQ-010 go  out  1  one-cycle copy request to the copy engine.
REQ-011 refresh  out  1  one-cycle buffer-to-screen request to the copy engine.
REQ-012 X  out  9  tile/screen origin x to copy engine.
REQ-013 Y  out  8  tile/screen origin y to copy engine.
REQ-014 memory_select  out  2  source select to copy engine (11 = tile set).
REQ-015 tile_select  out  4  tile index to copy engine.
REQ-016 finished  in  1  one-cycle completion pulse from copy engine.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when the redraw sequence completes.

Function
REQ-019 States: IDLE, BG_GO, BG_WAIT, FETCH, FETCH_WAIT, TILE_GO, TILE_WAIT, NEXT, REF_GO, REF_WAIT, DONE.
REQ-020 IDLE: start=1 -> BG_GO, latch bg_sel, clear col/row counters; else stay.
REQ-021 BG_GO: go=1, memory_select=bg_sel, X=0, Y=0 for exactly one cycle -> BG_WAIT.
REQ-022 BG_WAIT: finished=1 -> FETCH; else stay; no timeout.
REQ-023 FETCH: map_addr=row*COLS+col -> FETCH_WAIT; FETCH_WAIT: register map_tile into tile_select -> TILE_GO.
REQ-024 TILE_GO: go=1, memory_select=11, X=col*TILE, Y=row*TILE for one cycle -> TILE_WAIT.
REQ-025 TILE_WAIT: finished=1 -> NEXT; else stay.
REQ-026 NEXT: col wraps COLS-1 -> 0 with row+1; after col=COLS-1,row=ROWS-1 -> REF_GO; else -> FETCH.
REQ-027 REF_GO: refresh=1 one cycle -> REF_WAIT; finished=1 -> DONE.
REQ-028 DONE: done=1 one cycle -> IDLE.
REQ-029 X, Y, memory_select, tile_select are registered and stay stable from the go/refresh cycle until finished is seen.
REQ-030 go and refresh are never high in the same cycle; at most one request outstanding.
REQ-031 finished in any state other than BG_WAIT, TILE_WAIT, REF_WAIT is ignored.
REQ-032 start while busy=1 is ignored; no queuing.
REQ-033 Latency: start sampled at edge N -> go high in cycle N+1; finished at edge M in TILE_WAIT -> next tile go at M+4.
REQ-034 X/Y arithmetic is unsigned; col*TILE fits 9 bits, row*TILE fits 8 bits for default parameters.

Reset
REQ-035 reset_n=0 at an edge forces IDLE, overriding any in-flight state, including mid-wait.
REQ-036 Reset values: go=0, refresh=0, done=0, busy=0, X=0, Y=0, memory_select=00, tile_select=0, map_addr=0, counters=0.

Configuration
REQ-037 Macro SKIP_EMPTY_TILES_EN defined: in FETCH_WAIT, map_tile=0 skips TILE_GO/TILE_WAIT and goes straight to NEXT.
REQ-038 Macro SKIP_EMPTY_TILES_EN undefined: every tile, including code 0, issues a go.

Verification
REQ-039 All map cells = 5, bg_sel=01, finished 3 cycles after each go -> 1 bg go, 300 tile go with memory_select=11, tile_select=5, last X=304, Y=224, one refresh, one done.
REQ-040 Cell (3,2) = 9 -> its go shows map_addr=43, X=48, Y=32, tile_select=9.
REQ-041 start pulsed while busy -> ignored; exactly one done per accepted start.
REQ-042 reset_n=0 during TILE_WAIT -> next cycle all outputs at reset values, busy=0; later start restarts at col=0,row=0.
REQ-043 SKIP_EMPTY_TILES_EN defined, map all 0 except one cell = 7 -> 1 bg go, 1 tile go, 1 refresh, done.
REQ-044 Spurious finished in IDLE and FETCH -> no state change, no go/refresh emitted.
